// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, imem req/ack fetch, registered instruction to decoder, redirect/flush handling
module instr_fetch #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [15:0]         instr,
    output logic [4:0]          opcode,
    output logic [PC_WIDTH-1:0] instr_pc
);
    typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HOLD} state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] pend_pc;

    assign imem_addr = fetch_pc;
    assign opcode    = instr[15:11];

    // Fetch FSM; a request in flight is never abandoned, so redirects during it are parked in pend_pc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            fetch_pc    <= RESET_PC;
            pend_pc     <= RESET_PC;
            instr       <= 16'h0000;
            instr_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack && redirect_valid) begin
                        fetch_pc <= redirect_pc;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= fetch_pc;
                        fetch_pc    <= fetch_pc + 1'b1;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end else if (redirect_valid) begin
                        pend_pc <= redirect_pc;
                        state   <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (imem_ack) begin
                        fetch_pc <= redirect_valid ? redirect_pc : pend_pc;
                        state    <= FETCH;
                    end else if (redirect_valid) begin
                        pend_pc <= redirect_pc;
                    end
                end
                HOLD: begin
                    if (redirect_valid || instr_ready) begin
                        fetch_pc    <= redirect_valid ? redirect_pc : fetch_pc;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: vector table plus scoreboard of captured instructions for instr_fetch
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic [15:0] instr_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ack;
        logic [15:0] rdata;
        logic        rv;
        logic [15:0] rpc;
        logic        ready;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
    } vec_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } cap_t;

    vec_t vecs[$];
    cap_t sb[$];
    cap_t last;

    instr_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .opcode(opcode), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ack, input logic [15:0] rdata, input logic rv, input logic [15:0] rpc,
                       input logic ready, input logic er, input logic [15:0] ea, input logic ev);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.rv = rv; v.rpc = rpc; v.ready = ready;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev;
        vecs.push_back(v);
    endtask

    task automatic pop_check(input string name);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected capture instr=%h pc=%h, scoreboard empty", name, instr, instr_pc);
        end else begin
            last = sb.pop_front();
            checks--;
            chk({name, "_instr"}, 32'(instr), 32'(last.instr));
            chk({name, "_opcode"}, 32'(opcode), 32'(last.instr[15:11]));
            chk({name, "_pc"}, 32'(instr_pc), 32'(last.pc));
        end
    endtask

    initial begin
        logic        prev_valid;
        logic [15:0] prev_addr;
        bit          seen;
        //  ack rdata     rv rpc       rdy  req addr      valid
        add(1, 16'h0800, 0, 16'h0000, 0,   0, 16'h0001, 1);
        add(0, 16'h0000, 0, 16'h0000, 0,   0, 16'h0001, 1);
        add(0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0001, 0);
        add(0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0001, 0);
        add(0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0001, 0);
        add(0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0001, 0);
        add(1, 16'hA123, 0, 16'h0000, 0,   0, 16'h0002, 1);
        add(0, 16'h0000, 0, 16'h0000, 0,   0, 16'h0002, 1);
        add(0, 16'h0000, 0, 16'h0000, 0,   0, 16'h0002, 1);
        add(0, 16'h0000, 0, 16'h0000, 0,   0, 16'h0002, 1);
        add(0, 16'h0000, 0, 16'h0000, 0,   0, 16'h0002, 1);
        add(0, 16'h0000, 1, 16'h0040, 1,   1, 16'h0040, 0);
        add(1, 16'h1234, 0, 16'h0000, 0,   0, 16'h0041, 1);
        add(0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0041, 0);
        add(0, 16'h0000, 1, 16'h0010, 0,   1, 16'h0041, 0);
        add(0, 16'h0000, 1, 16'h0020, 0,   1, 16'h0041, 0);
        add(0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0041, 0);
        add(1, 16'hDEAD, 0, 16'h0000, 0,   1, 16'h0020, 0);
        add(1, 16'h5555, 0, 16'h0000, 0,   0, 16'h0021, 1);
        add(0, 16'h0000, 1, 16'hFFFF, 0,   1, 16'hFFFF, 0);
        add(1, 16'h7777, 0, 16'h0000, 0,   0, 16'h0000, 1);
        add(0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0000, 0);
        add(1, 16'h8888, 0, 16'h0000, 0,   0, 16'h0001, 1);
        add(0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0001, 0);
        add(1, 16'hCCCC, 1, 16'h0030, 0,   1, 16'h0030, 0);
        add(1, 16'h9999, 0, 16'h0000, 0,   0, 16'h0031, 1);
        add(1, 16'hBBBB, 0, 16'h0000, 0,   0, 16'h0031, 1);
        add(0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0031, 0);
        add(0, 16'h0000, 1, 16'h0050, 0,   1, 16'h0031, 0);
        add(1, 16'hEEEE, 1, 16'h0060, 0,   1, 16'h0060, 0);
        add(0, 16'h0000, 1, 16'h0070, 0,   1, 16'h0060, 0);

        #2;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_opcode", 32'(opcode), 32'h0);
        chk("rst_pc", 32'(instr_pc), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("start_req", 32'(imem_req), 32'd1);
        chk("start_addr", 32'(imem_addr), 32'h0);
        chk("start_valid", 32'(instr_valid), 32'd0);

        prev_valid = 1'b0;
        prev_addr = 16'h0000;
        foreach (vecs[i]) begin
            imem_ack = vecs[i].ack;
            imem_rdata = vecs[i].rdata;
            redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc;
            instr_ready = vecs[i].ready;
            if (vecs[i].ack && vecs[i].exp_valid && !prev_valid)
                sb.push_back('{instr: vecs[i].rdata, pc: prev_addr});
            @(negedge clk);
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            if (instr_valid && !prev_valid)
                pop_check($sformatf("v%0d_cap", i));
            else if (vecs[i].exp_valid)
                chk($sformatf("v%0d_hold_instr", i), 32'(instr), 32'(last.instr));
            prev_valid = vecs[i].exp_valid;
            prev_addr = vecs[i].exp_addr;
        end
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;

        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'h0);
        chk("arst_instr", 32'(instr), 32'h0);
        imem_ack = 1'b1;
        imem_rdata = 16'hF00D;
        @(negedge clk);
        chk("arst_hold_req", 32'(imem_req), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("post_req", 32'(imem_req), 32'd1);
        chk("post_addr", 32'(imem_addr), 32'h0);
        chk("post_valid", 32'(instr_valid), 32'd0);
        chk("post_instr", 32'(instr), 32'h0);

        imem_ack = 1'b1;
        imem_rdata = 16'h0800;
        sb.push_back('{instr: 16'h0800, pc: 16'h0000});
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            seen = instr_valid;
        end
        if (seen) pop_check("final_cap");
        else chk("final_timeout", 32'd0, 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 16-bit instruction decoder datapath.
- Holds the program counter and issues word reads to instruction memory with a req/ack handshake.
- Registers each returned instruction word and presents it to main_decoder with a valid/ready handshake; `opcode` feeds main_decoder's Opcode[15:11] directly.
- Accepts PC redirects from downstream branch/jump resolution and discards wrong-path fetches.

## Interface
Parameters:
- PC_WIDTH, 16, width of the program counter and the instruction-memory word address.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_WIDTH  word address; stable while imem_req=1 and no ack has been seen.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  in  16  instruction word.
- redirect_valid  in  1  one-cycle redirect request.
- redirect_pc  in  PC_WIDTH  redirect target.
- instr_valid  out  1  instr and instr_pc hold a live instruction.
- instr_ready  in  1  decoder accepts the instruction.
- instr  out  16  registered instruction word.
- opcode  out  5  equals instr[15:11].
- instr_pc  out  PC_WIDTH  address the instruction was fetched from.

## Operation
Registers:
- fetch_pc drives imem_addr.
- pend_pc holds the redirect target captured while the stale request is outstanding.

States and transitions:
- IDLE: entered on reset. imem_req=0. Unconditionally goes to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=fetch_pc.
  - imem_ack without redirect: instr<=imem_rdata, instr_pc<=fetch_pc, fetch_pc<=fetch_pc+1, go HOLD.
  - imem_ack with redirect_valid in the same cycle: discard the data, fetch_pc<=redirect_pc, stay in FETCH.
  - redirect_valid without ack: pend_pc<=redirect_pc, go FLUSH. fetch_pc is unchanged so the address stays stable.
- FLUSH: imem_req=1, imem_addr=fetch_pc (stale address).
  - Another redirect_valid: pend_pc<=redirect_pc. The last redirect wins.
  - imem_ack: discard the data, fetch_pc<=pend_pc, or redirect_pc if a redirect arrives in the same cycle; go FETCH.
- HOLD: instr_valid=1, imem_req=0.
  - instr_ready=1: go FETCH.
  - redirect_valid=1: fetch_pc<=redirect_pc, go FETCH, and the held instruction is dropped. This takes priority over instr_ready in the same cycle: the instruction is not counted as consumed.

Rules:
- The PC increment wraps modulo 2^PC_WIDTH: max value +1 gives 0.
- instr, instr_pc and opcode change only when a new word is captured. They hold their value while instr_valid=0.
- An imem_ack in IDLE or HOLD is a protocol error and is ignored; no state change.

## Timing
Reset values (asynchronous):
- state=IDLE, imem_req=0, imem_addr=fetch_pc=pend_pc=RESET_PC.
- instr_valid=0, instr=16'h0000, opcode=5'b00000, instr_pc=0.

Cycle-level behaviour:
- First imem_req=1: the first rising edge after rst_n deasserts (cycle 1); cycle 0 is IDLE.
- Fetch latency: if ack arrives in cycle N, instr_valid=1 from cycle N+1.
- Zero-wait memory (ack in the first req cycle): throughput is one instruction per 2 cycles (FETCH, HOLD) with instr_ready held high.
- Redirect in HOLD at cycle N: instr_valid=0 and imem_req=1 with imem_addr=redirect_pc at N+1.
- Redirect in FETCH with no ack: the stale request stays asserted until ack. The new address appears the cycle after that ack.
- instr_valid stays high with instr stable until it is accepted or flushed; it never drops on its own.
- Reset asserted mid-fetch: all outputs return to reset values immediately, and any later ack is ignored (IDLE).

## Test plan
- Reset/startup: RESET_PC=0, memory acks in the first req cycle returning 16'h0800 (opcode 00001) -> imem_req rises in cycle 1 with addr 0, instr_valid=1 in cycle 2, instr=16'h0800, opcode=5'b00001, instr_pc=0.
- Wait states and backpressure: ack delayed 3 cycles, instr_ready low for 4 cycles -> imem_addr stable during the wait, instr_valid held with instr unchanged, next request addr=1 only after ready.
- Redirect in HOLD with instr_ready=1 in the same cycle, redirect_pc=16'h0040 -> instruction dropped, next imem_addr=16'h0040, next instr_pc=16'h0040.
- Redirect while a fetch is outstanding: redirects to 16'h0010 then 16'h0020 during FLUSH, then ack -> stale data never appears on instr (instr_valid stays 0), following request addr=16'h0020.
- Wrap-around: redirect to 16'hFFFF, two sequential fetches -> instr_pc 16'hFFFF then 16'h0000.
- Async reset asserted in FLUSH -> imem_req and instr_valid go to 0 immediately, imem_addr=RESET_PC, and a later ack has no effect.
